// File: rtl/iter_div.sv
// Signed 32-bit iterative restoring divider: one quotient bit per clock.
// Quotient truncates toward zero; the remainder takes the dividend's sign.
module iter_div (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic [31:0] data_remainder,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] q_q, q_d;
    logic [31:0] b_q, b_d;
    logic [31:0] r_q, r_d;
    logic [31:0] result_q, result_d;
    logic [31:0] rem_q, rem_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        q_sign_q, q_sign_d;
    logic        r_sign_q, r_sign_d;
    logic        ovf_q, ovf_d;
    logic        exc_q, exc_d;

    logic [31:0] a_mag, b_mag;
    logic [32:0] r_shift, r_trial;
    logic [31:0] r_next, q_next;

    always_comb begin
        // Negation wraps, so |0x80000000| lands on unsigned 0x80000000.
        a_mag = data_operandA[31] ? (32'd0 - data_operandA) : data_operandA;
        b_mag = data_operandB[31] ? (32'd0 - data_operandB) : data_operandB;

        r_shift = {r_q, q_q[31]};
        r_trial = r_shift - {1'b0, b_q};
        if (!r_trial[32]) begin
            r_next = r_trial[31:0];
            q_next = {q_q[30:0], 1'b1};
        end else begin
            r_next = r_shift[31:0];
            q_next = {q_q[30:0], 1'b0};
        end
    end

    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        b_d      = b_q;
        r_d      = r_q;
        cnt_d    = cnt_q;
        q_sign_d = q_sign_q;
        r_sign_d = r_sign_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        rem_d    = rem_q;
        exc_d    = exc_q;

        case (state_q)
            IDLE, DONE: begin
                if (ctrl_DIV) begin
                    q_d      = a_mag;
                    b_d      = b_mag;
                    r_d      = 32'd0;
                    cnt_d    = 5'd0;
                    q_sign_d = data_operandA[31] ^ data_operandB[31];
                    r_sign_d = data_operandA[31];
                    ovf_d    = (data_operandA == 32'h8000_0000) &&
                               (data_operandB == 32'hFFFF_FFFF);
                    exc_d    = 1'b0;
                    if (data_operandB == 32'd0) begin
                        state_d  = DONE;
                        result_d = 32'd0;
                        rem_d    = 32'd0;
                        exc_d    = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                q_d   = q_next;
                r_d   = r_next;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d  = DONE;
                    result_d = q_sign_q ? (32'd0 - q_next) : q_next;
                    rem_d    = r_sign_q ? (32'd0 - r_next) : r_next;
                    exc_d    = ovf_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            q_q      <= 32'd0;
            b_q      <= 32'd0;
            r_q      <= 32'd0;
            cnt_q    <= 5'd0;
            q_sign_q <= 1'b0;
            r_sign_q <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= 32'd0;
            rem_q    <= 32'd0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            b_q      <= b_d;
            r_q      <= r_d;
            cnt_q    <= cnt_d;
            q_sign_q <= q_sign_d;
            r_sign_q <= r_sign_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            exc_q    <= exc_d;
        end
    end

    assign data_result    = result_q;
    assign data_remainder = rem_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == DONE);
    assign busy           = (state_q == RUN);

endmodule
